// File: rtl/mul_hilo_stage.sv
// Multicycle multiply sequencer: registers operands for an external combinational
// multiplier, waits MUL_CYCLES, then captures the 64-bit product into HI/LO.
module mul_hilo_stage #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start) begin
                    mul_a_d = a_in;
                    mul_b_d = b_in;
                    cnt_d   = CNT_INIT;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Direct writes are deliberately dropped here, not queued.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hi_d    = mul_p[63:32];
                    lo_d    = mul_p[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = (state_q == MUL);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Directed bench for mul_hilo_stage: vector table plus hand-written corner sequences,
// with a behavioural multiplier closing the mul_a/mul_b -> mul_p loop.
module tb_mul_hilo_stage;

    logic        clk = 1'b0;
    logic        rst, start, start_s, hi_wr, lo_wr;
    logic [31:0] a_in, b_in, wr_data;

    logic [31:0] mul_a, mul_b, hi, lo;
    logic [63:0] mul_p;
    logic        busy, done;

    logic [31:0] mul_a1, mul_b1, hi1, lo1;
    logic [63:0] mul_p1;
    logic        busy1, done1;

    logic [31:0] mul_a15, mul_b15, hi15, lo15;
    logic [63:0] mul_p15;
    logic        busy15, done15;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    // Sign-extended unsigned multiply yields the exact low 64 bits of the signed product.
    assign mul_p   = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    assign mul_p1  = {{32{mul_a1[31]}}, mul_a1} * {{32{mul_b1[31]}}, mul_b1};
    assign mul_p15 = {{32{mul_a15[31]}}, mul_a15} * {{32{mul_b15[31]}}, mul_b15};

    mul_hilo_stage #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mul_hilo_stage #(.MUL_CYCLES(1)) dut_mc1 (
        .clk(clk), .rst(rst), .start(start_s), .a_in(a_in), .b_in(b_in),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
        .hi_wr(1'b0), .lo_wr(1'b0), .wr_data(wr_data),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    mul_hilo_stage #(.MUL_CYCLES(15)) dut_mc15 (
        .clk(clk), .rst(rst), .start(start_s), .a_in(a_in), .b_in(b_in),
        .mul_a(mul_a15), .mul_b(mul_b15), .mul_p(mul_p15),
        .hi_wr(1'b0), .lo_wr(1'b0), .wr_data(wr_data),
        .busy(busy15), .done(done15), .hi(hi15), .lo(lo15)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a multiply on the MUL_CYCLES=2 instance and verify latency, stability and result.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        logic stable;
        start = 1'b1; a_in = a; b_in = b;
        step();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        stable = 1'b1;
        while (!done && lat < 40) begin
            if (mul_a !== a || mul_b !== b) stable = 1'b0;
            step();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check({tag, "_stable"}, 64'(stable), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_idle"}, 64'(busy), 64'd0);
        step();
        check({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, lat1, lat15;
        logic stable;
        logic [31:0] lo_before;

        vecs[0] = '{32'd5,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{32'h7FFF_FFFF, 32'd2,        32'h0000_0000, 32'hFFFF_FFFE};
        vecs[4] = '{32'd3,        32'd4,        32'h0000_0000, 32'd12};
        vecs[5] = '{32'd0,        32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{32'hFFFF_FFFF, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF9};

        rst = 1'b1; start = 1'b0; start_s = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        a_in = '0; b_in = '0; wr_data = '0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_mulab", {mul_a, mul_b}, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Start held through busy: second request ignored, then accepted in the done cycle.
        start = 1'b1; a_in = 32'd3; b_in = 32'd4;
        step();
        a_in = 32'd6; b_in = 32'd7;
        step();
        check("b2b_mula_hold", 64'(mul_a), 64'd3);
        step();
        check("b2b_done1", 64'(done), 64'd1);
        check("b2b_first", {hi, lo}, 64'd12);
        lat = 0;
        step();
        lat++;
        start = 1'b0;
        check("b2b_accept", 64'(busy), 64'd1);
        check("b2b_mula2", 64'(mul_a), 64'd6);
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        check("b2b_gap", 64'(lat), 64'd3);
        check("b2b_second", {hi, lo}, 64'd42);
        step();

        // Direct write to HI in IDLE leaves LO alone.
        lo_before = lo;
        hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
        step();
        hi_wr = 1'b0;
        check("wr_hi", 64'(hi), 64'hDEAD_BEEF);
        check("wr_hi_lo_keep", 64'(lo), 64'(lo_before));

        // Write coinciding with start takes effect, then the capture overwrites it.
        start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hAAAA_5555;
        a_in = 32'd5; b_in = 32'hFFFF_FFFD;
        step();
        start = 1'b0; hi_wr = 1'b0;
        check("wr_start_hilo", {hi, lo}, 64'hAAAA_5555_AAAA_5555);
        check("wr_start_busy", 64'(busy), 64'd1);
        wr_data = 32'h1234_5678;
        step();
        lo_wr = 1'b0;
        check("wr_mul_ignored", 64'(lo), 64'hAAAA_5555);
        step();
        check("wr_mul_done", 64'(done), 64'd1);
        check("wr_mul_capture", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        step();

        // Reset one cycle into a multiply aborts it with no done pulse.
        start = 1'b1; a_in = 32'd9; b_in = 32'd9;
        step();
        start = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_hilo", {hi, lo}, 64'd0);
        check("rstmid_mulab", {mul_a, mul_b}, 64'd0);
        stable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) stable = 1'b1;
            step();
        end
        check("rstmid_no_done", 64'(stable), 64'd0);

        // Parameter sweep: MUL_CYCLES=1 and 15 run side by side.
        start_s = 1'b1; a_in = 32'd5; b_in = 32'hFFFF_FFFD;
        step();
        start_s = 1'b0;
        a_in = 32'h0BAD_0BAD; b_in = 32'h0BAD_0BAD;
        lat1 = -1; lat15 = -1; stable = 1'b1;
        for (int i = 1; i <= 30 && lat15 < 0; i++) begin
            if (busy15 && (mul_a15 !== 32'd5 || mul_b15 !== 32'hFFFF_FFFD)) stable = 1'b0;
            if (busy1 && (mul_a1 !== 32'd5 || mul_b1 !== 32'hFFFF_FFFD)) stable = 1'b0;
            step();
            if (done1 && lat1 < 0) lat1 = i;
            if (done15 && lat15 < 0) lat15 = i;
        end
        check("mc1_lat", 64'(lat1), 64'd1);
        check("mc15_lat", 64'(lat15), 64'd15);
        check("sweep_stable", 64'(stable), 64'd1);
        check("mc1_hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mc15_hilo", {hi15, lo15}, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mc1_mula_after", 64'(mul_a1), 64'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
